// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART Tx arbiter.
// Contents: FSM state encoding, the serial timing defaults, and the default
// watchdog and guard lengths derived from them.
package uart_tx_arbiter_pkg;

   localparam int unsigned SYS_CLK      = 50_000_000;
   localparam int unsigned BAUD_RATE    = 115_200;
   // One 8N1 frame is 10 bit times.
   localparam int unsigned FRAME_CYCLES = (SYS_CLK / BAUD_RATE) * 10;
   // The watchdog default is the next power of two above one frame (8192 at 50 MHz).
   localparam int unsigned TIMEOUT_DEF  = 1 << $clog2(FRAME_CYCLES + 1);
   localparam int unsigned GUARD_DEF    = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_WAIT  = 2'd2,
      ST_GUARD = 2'd3
   } state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, reusable for any shared resource.
// Ports:
//   req_i   - request vector
//   ptr_i   - index that has the highest priority this cycle
//   mask_i  - eligibility mask; a requester needs both req and mask set
//   gnt_o   - one-hot winner (all zero when nothing is eligible)
//   idx_o   - winner index
//   valid_o - a winner exists
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   input  logic [N-1:0]  mask_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   logic [N-1:0] elig;

   assign elig = req_i & mask_i;

   // Scan from the farthest offset down to offset 0, so the eligible requester
   // closest to the pointer is the last one written and wins.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (elig[(int'(ptr_i) + i) % N]) begin
            gnt_o                            = '0;
            gnt_o[(int'(ptr_i) + i) % N]     = 1'b1;
            idx_o                            = IW'((int'(ptr_i) + i) % N);
            valid_o                          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART Tx serializer among NUM_REQ byte sources.
// Ports:
//   clk, rst       - system clock, async active-high reset
//   i_req/i_req_d  - per-requester byte valid (level) and byte data (8 bits each)
//   i_lock         - requester keeps ownership across bytes while set
//   o_grant        - one-hot pulse: byte accepted from that requester
//   o_tx_start     - one-cycle start to the serializer
//   o_tx_d         - byte to serializer, held from start until complete
//   i_tx_complete  - serializer end-of-frame pulse
//   o_busy         - high outside IDLE
//   o_owner        - index of the current/last owner
//   o_tx_error     - one-cycle pulse on watchdog expiry
//
// state | meaning
// IDLE  | arbitrate; honour a held lock; release a dropped lock (no grant that cycle)
// LOAD  | byte latched, grant visible; start pulse issued on exit
// WAIT  | frame in flight; watchdog counting
// GUARD | idle gap after a frame before arbitrating again
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int TIMEOUT = TIMEOUT_DEF,
   parameter  int GUARD   = GUARD_DEF,
   localparam int IW      = $clog2(NUM_REQ),
   localparam int WW      = $clog2(TIMEOUT + 1),
   localparam int GW      = (GUARD > 1) ? $clog2(GUARD) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   i_req,
   input  logic [8*NUM_REQ-1:0] i_req_d,
   input  logic [NUM_REQ-1:0]   i_lock,
   output logic [NUM_REQ-1:0]   o_grant,
   output logic                 o_tx_start,
   output logic [7:0]           o_tx_d,
   input  logic                 i_tx_complete,
   output logic                 o_busy,
   output logic [IW-1:0]        o_owner,
   output logic                 o_tx_error
);

   state_e               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic                 start_q, start_d;
   logic [7:0]           txd_q, txd_d;
   logic [IW-1:0]        owner_q, owner_d;
   logic                 err_q, err_d;
   logic [IW-1:0]        ptr_q, ptr_d;
   logic                 lock_vld_q, lock_vld_d;
   logic [IW-1:0]        lock_own_q, lock_own_d;
   logic [WW-1:0]        wdog_q, wdog_d;
   logic [GW-1:0]        gcnt_q, gcnt_d;

   logic                 lock_hold;
   logic [NUM_REQ-1:0]   arb_mask;
   logic [NUM_REQ-1:0]   arb_gnt;
   logic [IW-1:0]        arb_idx;
   logic                 arb_valid;

   // A held lock makes its owner the only eligible requester.
   assign lock_hold = lock_vld_q && i_lock[lock_own_q];
   assign arb_mask  = lock_hold ? (NUM_REQ'(1) << lock_own_q) : '1;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req_i   (i_req),
      .ptr_i   (ptr_q),
      .mask_i  (arb_mask),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   always_comb begin
      state_d    = state_q;
      grant_d    = '0;
      start_d    = 1'b0;
      txd_d      = txd_q;
      owner_d    = owner_q;
      err_d      = 1'b0;
      ptr_d      = ptr_q;
      lock_vld_d = lock_vld_q;
      lock_own_d = lock_own_q;
      wdog_d     = wdog_q;
      gcnt_d     = gcnt_q;
      case (state_q)
         ST_IDLE: begin
            if (lock_vld_q && !i_lock[lock_own_q]) begin
               lock_vld_d = 1'b0;
            end else if (arb_valid) begin
               grant_d = arb_gnt;
               txd_d   = i_req_d[{arb_idx, 3'b000} +: 8];
               owner_d = arb_idx;
               if (i_lock[arb_idx]) begin
                  lock_vld_d = 1'b1;
                  lock_own_d = arb_idx;
               end else begin
                  lock_vld_d = 1'b0;
                  ptr_d      = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);
               end
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            start_d = 1'b1;
            wdog_d  = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // Completion is tested first so it wins over a coincident timeout.
            if (i_tx_complete) begin
               gcnt_d  = '0;
               state_d = ST_GUARD;
            end else if (wdog_q == WW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               gcnt_d  = '0;
               state_d = ST_GUARD;
            end else if (wdog_q != WW'(TIMEOUT)) begin
               wdog_d = wdog_q + WW'(1);
            end
         end
         ST_GUARD: begin
            if (GUARD <= 1 || gcnt_q == GW'(GUARD - 1)) begin
               state_d = ST_IDLE;
            end else begin
               gcnt_d = gcnt_q + GW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         start_q    <= 1'b0;
         txd_q      <= 8'h00;
         owner_q    <= '0;
         err_q      <= 1'b0;
         ptr_q      <= '0;
         lock_vld_q <= 1'b0;
         lock_own_q <= '0;
         wdog_q     <= '0;
         gcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         start_q    <= start_d;
         txd_q      <= txd_d;
         owner_q    <= owner_d;
         err_q      <= err_d;
         ptr_q      <= ptr_d;
         lock_vld_q <= lock_vld_d;
         lock_own_q <= lock_own_d;
         wdog_q     <= wdog_d;
         gcnt_q     <= gcnt_d;
      end
   end

   assign o_grant    = grant_q;
   assign o_tx_start = start_q;
   assign o_tx_d     = txd_q;
   assign o_owner    = owner_q;
   assign o_tx_error = err_q;
   assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level reference model (round-robin
// pick, lock owner, frame/guard timing) with a bench-driven serializer.
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int TO = 200;
   localparam int GD = 2;
   localparam int IW = 2;
   localparam int G1 = (GD < 1) ? 1 : GD;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req = '0;
   logic [N-1:0]   lock = '0;
   logic [7:0]     dat [N];
   logic [8*N-1:0] req_d;
   logic [N-1:0]   grant;
   logic           tx_start;
   logic [7:0]     tx_d;
   logic           tx_complete = 1'b0;
   logic           busy;
   logic [IW-1:0]  owner;
   logic           tx_error;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // reference model state
   int m_ptr  = 0;
   bit m_lvld = 1'b0;
   int m_lown = 0;
   int evt_cyc = 0;
   bit have_evt = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      req_d = '0;
      for (int k = 0; k < N; k++) req_d[8*k +: 8] = dat[k];
   end

   uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .GUARD(GD)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_req         (req),
      .i_req_d       (req_d),
      .i_lock        (lock),
      .o_grant       (grant),
      .o_tx_start    (tx_start),
      .o_tx_d        (tx_d),
      .i_tx_complete (tx_complete),
      .o_busy        (busy),
      .o_owner       (owner),
      .o_tx_error    (tx_error)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Winner under the lock/round-robin rules, or -1 when nobody is eligible.
   function automatic int pick(input logic [N-1:0] r, input logic [N-1:0] l);
      if (m_lvld && l[m_lown]) return r[m_lown] ? m_lown : -1;
      for (int i = 0; i < N; i++)
         if (r[(m_ptr + i) % N]) return (m_ptr + i) % N;
      return -1;
   endfunction

   // One byte transaction. d>0: serializer completes d cycles after start;
   // d==0: serializer never completes (watchdog); d<0: reset after -d cycles in WAIT.
   task automatic serve(input int d, input logic [7:0] nxt, input bit keep, input bit nlock);
      int w, n, extra, s, pulses, first_err, lim;
      logic [7:0] b;
      bit ok;
      extra = 0;
      if (m_lvld && !lock[m_lown]) begin
         m_lvld = 1'b0;
         extra  = 1;
      end
      w = pick(req, lock);
      if (w < 0) begin
         $display("FAIL no_eligible: got none required a requester");
         $fatal(1, "bench setup error");
      end
      n = 0;
      do begin
         @(negedge clk);
         tx_complete = 1'b0;
         n++;
      end while (grant == '0 && n < 40);
      chk("grant", 64'(grant), 64'(1 << w));
      chk("owner", 64'(owner), 64'(w));
      chk("tx_d", 64'(tx_d), 64'(dat[w]));
      chk("start_early", 64'(tx_start), 64'(0));
      if (have_evt) chk("gap", 64'(cyc - evt_cyc), 64'(G1 + 2 + extra));
      else          chk("latency", 64'(n), 64'(1));
      b = dat[w];
      if (lock[w]) begin
         m_lvld = 1'b1;
         m_lown = w;
      end else begin
         m_lvld = 1'b0;
         m_ptr  = (w + 1) % N;
      end
      dat[w]  = nxt;
      req[w]  = keep;
      lock[w] = nlock;
      @(negedge clk);
      chk("start", 64'({tx_start, busy}), 64'(2'b11));
      s = cyc;
      ok = 1'b1;
      pulses = 0;
      first_err = 0;
      lim = (d > 0) ? d : (d == 0 ? TO : -d);
      for (int j = 1; j <= lim; j++) begin
         @(negedge clk);
         if (tx_d !== b || tx_start !== 1'b0 || grant !== '0 || busy !== 1'b1) ok = 1'b0;
         if (tx_error) begin
            pulses++;
            if (first_err == 0) first_err = j;
         end
      end
      if (d < 0) begin
         rst = 1'b1;
         #1;
         chk("rst_async", 64'({grant, tx_start, tx_d, busy, owner, tx_error}), 64'(0));
         chk("hold", 64'(ok), 64'(1));
         @(negedge clk);
         rst = 1'b0;
         m_ptr = 0;
         m_lvld = 1'b0;
         m_lown = 0;
         have_evt = 1'b0;
         return;
      end
      if (d > 0) begin
         chk("no_err", 64'(pulses), 64'(0));
         evt_cyc = cyc;
      end else begin
         chk("err_timing", {32'(pulses), 32'(first_err)}, {32'd1, 32'(TO)});
         evt_cyc = s + TO - 1;
      end
      // Complete in WAIT ends the frame; after a timeout it lands in GUARD and is ignored.
      tx_complete = 1'b1;
      @(negedge clk);
      tx_complete = 1'b0;
      chk("err_after", 64'({tx_error, busy}), 64'(2'b01));
      chk("hold", 64'(ok), 64'(1));
      have_evt = 1'b1;
   endtask

   initial begin
      logic [N-1:0] r, l;
      int sel, dd;
      for (int k = 0; k < N; k++) dat[k] = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_outs", 64'({grant, tx_start, tx_d, busy, owner, tx_error}), 64'(0));
      rst = 1'b0;

      // all requesting, no locks: round-robin 0,1,2,3,0
      for (int k = 0; k < N; k++) dat[k] = 8'($urandom);
      req = '1;
      for (int t = 0; t < 5; t++) serve(100, 8'($urandom), 1'b1, 1'b0);

      // requester 2 locks for A1,A2, drops the lock for A3
      req = 4'b0101;
      lock = 4'b0100;
      dat[2] = 8'hA1;
      serve(100, 8'hA2, 1'b1, 1'b1);
      serve(100, 8'hA3, 1'b1, 1'b0);
      serve(100, 8'h00, 1'b0, 1'b0);
      serve(100, 8'($urandom), 1'b1, 1'b0);

      // watchdog expiry, then complete coinciding with the timeout
      req = '1;
      serve(0, 8'($urandom), 1'b0, 1'b0);
      serve(TO - 1, 8'($urandom), 1'b0, 1'b0);

      // reset mid-frame with requests pending, then requester 0 first
      serve(-10, 8'($urandom), 1'b1, 1'b0);
      req = '1;
      serve(100, 8'($urandom), 1'b1, 1'b0);

      // requester byte changes after grant must not disturb o_tx_d
      req = 4'b0001;
      lock = '0;
      dat[0] = 8'h55;
      serve(100, 8'hFF, 1'b0, 1'b0);

      // complete while idle is ignored
      repeat (5) @(negedge clk);
      tx_complete = 1'b1;
      @(negedge clk);
      tx_complete = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_ignore", 64'({busy, grant, tx_start, tx_error}), 64'(0));
      have_evt = 1'b0;

      // randomized traffic
      for (int t = 0; t < 40; t++) begin
         r = 4'($urandom_range(1, 15));
         l = ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
         if (m_lvld && l[m_lown]) r[m_lown] = 1'b1;
         req = r;
         lock = l;
         for (int k = 0; k < N; k++) dat[k] = 8'($urandom);
         sel = $urandom_range(0, 9);
         dd = (sel == 0) ? 0 : (sel == 1) ? TO - 1 : $urandom_range(1, 150);
         serve(dd, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
